// File: rtl/clock_pkg.sv
// Shared types and constants for the time-setting controller.
package clock_pkg;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int HR_W    = 5;
  localparam int MIN_W   = 6;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_e;

  // Hour increment with 23 -> 0 wrap.
  function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
    return (v >= HR_W'(HR_MAX)) ? '0 : v + HR_W'(1);
  endfunction

  // Minute increment with 59 -> 0 wrap.
  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] v);
    return (v >= MIN_W'(MIN_MAX)) ? '0 : v + MIN_W'(1);
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, running-time and edited-time signals between the controller and
// its environment (clock counter, display, pushbuttons).
interface time_set_ctrl_if;
  import clock_pkg::*;

  logic             btn_mode;
  logic             btn_inc;
  logic [HR_W-1:0]  cur_hr;
  logic [MIN_W-1:0] cur_min;
  logic [HR_W-1:0]  set_hr;
  logic [MIN_W-1:0] set_min;
  logic             load;
  logic             editing;
  logic             blank_hr;
  logic             blank_min;

  // Environment side: drives buttons and running time, observes the editor.
  modport master (
    output btn_mode, btn_inc, cur_hr, cur_min,
    input  set_hr, set_min, load, editing, blank_hr, blank_min
  );

  // Controller side.
  modport slave (
    input  btn_mode, btn_inc, cur_hr, cur_min,
    output set_hr, set_min, load, editing, blank_hr, blank_min
  );

endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, counter debouncer that
// accepts a new level after DEB_CYCLES identical samples, and a one-cycle
// pulse on each accepted press (0 -> 1 of the stable level).
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_done;

  // Current sample is the DEB_CYCLES-th consecutive one differing from stable.
  assign w_cnt_done = (r_cnt == CNT_W'(DEB_CYCLES - 1));

  // Synchronize, debounce and detect the rising edge of the stable level.
  // NOTE: every register here uses <= so all flops sample pre-edge values;
  // a blocking '=' would collapse the synchronizer chain into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_cnt_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: mode button walks RUN -> SET_HR -> SET_MIN -> RUN,
// inc button advances the field being edited, the edited field blinks, and
// leaving SET_MIN emits a one-cycle load strobe to the clock counter.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic           clk,
  input  logic           reset,
  time_set_ctrl_if.slave bus
);

  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_e           r_state;
  logic [HR_W-1:0]  r_set_hr;
  logic [MIN_W-1:0] r_set_min;
  logic             r_load;
  logic             r_editing;
  logic             r_blank_hr;
  logic             r_blank_min;
  logic             r_phase;
  logic [DIV_W-1:0] r_div;

  logic w_mode_p;
  logic w_inc_p;
  logic w_enter;
  logic w_div_wrap;
  logic w_phase_adv;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (bus.btn_mode),
    .o_press (w_mode_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (bus.btn_inc),
    .o_press (w_inc_p)
  );

  // A mode press from RUN or SET_HR lands in a set state: restart the blink.
  assign w_enter     = w_mode_p && (r_state != ST_SET_MIN);
  assign w_div_wrap  = (r_div == DIV_W'(BLINK_DIV - 1));
  // Blink phase as it will be after this edge, so blank outputs stay aligned.
  assign w_phase_adv = r_phase ^ w_div_wrap;

  // Mode FSM, edited values, blink divider and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_set_hr    <= '0;
      r_set_min   <= '0;
      r_load      <= 1'b0;
      r_editing   <= 1'b0;
      r_blank_hr  <= 1'b0;
      r_blank_min <= 1'b0;
      r_phase     <= 1'b0;
      r_div       <= '0;
    end else begin
      r_load <= 1'b0;

      if (w_enter) begin
        r_div   <= '0;
        r_phase <= 1'b0;
      end else if (w_div_wrap) begin
        r_div   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      unique case (r_state)
        ST_RUN: begin
          r_editing   <= 1'b0;
          r_blank_hr  <= 1'b0;
          r_blank_min <= 1'b0;
          if (w_mode_p) begin
            r_state   <= ST_SET_HR;
            r_set_hr  <= bus.cur_hr;
            r_set_min <= bus.cur_min;
            r_editing <= 1'b1;
          end
        end
        ST_SET_HR: begin
          r_blank_min <= 1'b0;
          if (w_mode_p) begin
            r_state    <= ST_SET_MIN;
            r_blank_hr <= 1'b0;
          end else begin
            r_blank_hr <= w_phase_adv;
            if (w_inc_p) r_set_hr <= inc_hr(r_set_hr);
          end
        end
        ST_SET_MIN: begin
          r_blank_hr <= 1'b0;
          if (w_mode_p) begin
            r_state     <= ST_RUN;
            r_load      <= 1'b1;
            r_editing   <= 1'b0;
            r_blank_min <= 1'b0;
          end else begin
            r_blank_min <= w_phase_adv;
            if (w_inc_p) r_set_min <= inc_min(r_set_min);
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_editing   <= 1'b0;
          r_blank_hr  <= 1'b0;
          r_blank_min <= 1'b0;
        end
      endcase
    end
  end

  assign bus.set_hr    = r_set_hr;
  assign bus.set_min   = r_set_min;
  assign bus.load      = r_load;
  assign bus.editing   = r_editing;
  assign bus.blank_hr  = r_blank_hr;
  assign bus.blank_min = r_blank_min;

endmodule
